// File: rtl/limp_rr_arbiter.sv
// Round-robin arbiter multiplexing NUM_PORTS LIMP requesters onto one downstream target,
// with AMO read/write lock. Define LIMP_ARB_ILLEGAL_CHECK_EN to reject bad size/cmd combos locally.
module limp_rr_arbiter #(
   parameter int unsigned NUM_PORTS   = 4,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned AMO_TIMEOUT = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [2*NUM_PORTS-1:0]        i_up_cmd,
   input  logic [ADDR_W*NUM_PORTS-1:0]   i_up_addr,
   input  logic [DATA_W*NUM_PORTS-1:0]   i_up_wdata,
   input  logic [2*NUM_PORTS-1:0]        i_up_size,
   output logic [2*NUM_PORTS-1:0]        o_up_status,
   output logic [DATA_W*NUM_PORTS-1:0]   o_up_rdata,
   output logic [1:0]                    o_dn_cmd,
   output logic [ADDR_W-1:0]             o_dn_addr,
   output logic [DATA_W-1:0]             o_dn_wdata,
   output logic [1:0]                    o_dn_size,
   input  logic [1:0]                    i_dn_status,
   input  logic [DATA_W-1:0]             i_dn_rdata,
   output logic [NUM_PORTS-1:0]          o_grant,
   output logic                          o_locked
);

   localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned CNT_W = $clog2(AMO_TIMEOUT + 1);

   typedef enum logic [1:0] {LIMP_NOP, LIMP_READ, LIMP_WRITE, LIMP_AMO_READ} cmd_e;
   typedef enum logic [1:0] {LIMP_NOT_READY, LIMP_READY_READ, LIMP_READY_WRITE,
                             LIMP_READY_ILLEGAL} status_e;
   typedef enum logic [1:0] {LIMP_BYTE, LIMP_HALF, LIMP_WORD, LIMP_SIZE_RSVD} size_e;
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_AMO_LOCK} state_e;

   state_e               state_q;
   logic [PTR_W-1:0]     ptr_q;
   logic [PTR_W-1:0]     gnt_idx_q;
   logic [NUM_PORTS-1:0] grant_q;
   logic                 locked_q;
   logic [CNT_W-1:0]     cnt_q;

   logic [1:0]        up_cmd   [NUM_PORTS];
   logic [ADDR_W-1:0] up_addr  [NUM_PORTS];
   logic [DATA_W-1:0] up_wdata [NUM_PORTS];
   logic [1:0]        up_size  [NUM_PORTS];

   logic                 sel_found;
   logic [PTR_W-1:0]     sel_idx;
   logic [PTR_W-1:0]     cand;
   logic [NUM_PORTS-1:0] sel_onehot;
   logic                 sel_bad;

   logic [1:0] own_cmd;
   logic       own_done;
   logic       own_amo_ok;
   logic       go_release;
   logic       go_lock;
   logic       cnt_clr;
   logic       cnt_inc;

   // Split the flat per-port buses into indexable arrays
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
      assign up_cmd[p]   = i_up_cmd[2*p +: 2];
      assign up_addr[p]  = i_up_addr[ADDR_W*p +: ADDR_W];
      assign up_wdata[p] = i_up_wdata[DATA_W*p +: DATA_W];
      assign up_size[p]  = i_up_size[2*p +: 2];
   end

   function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] idx);
      if (idx == PTR_W'(NUM_PORTS - 1)) return '0;
      return idx + PTR_W'(1);
   endfunction

   // First active port at or after the round-robin pointer
   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      cand       = '0;
      sel_onehot = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         cand = PTR_W'((32'(ptr_q) + i) % NUM_PORTS);
         if (!sel_found && up_cmd[cand] != LIMP_NOP) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
      sel_onehot[sel_idx] = 1'b1;
   end

`ifdef LIMP_ARB_ILLEGAL_CHECK_EN
   assign sel_bad = (up_size[sel_idx] == LIMP_SIZE_RSVD) ||
                    (up_cmd[sel_idx] == LIMP_AMO_READ && up_size[sel_idx] != LIMP_WORD);
`else
   assign sel_bad = 1'b0;
`endif

   assign own_cmd    = up_cmd[gnt_idx_q];
   assign own_done   = (i_dn_status != LIMP_NOT_READY);
   assign own_amo_ok = (own_cmd == LIMP_AMO_READ) && (i_dn_status == LIMP_READY_READ);

   // Owner-side transition decode; an owner dropping to NOP outside the lock is an abort
   always_comb begin
      go_release = 1'b0;
      go_lock    = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      case (state_q)
         ST_BUSY: begin
            if (own_cmd == LIMP_NOP)  go_release = 1'b1;
            else if (own_done) begin
               if (own_amo_ok) go_lock    = 1'b1;
               else            go_release = 1'b1;
            end
         end
         ST_AMO_LOCK: begin
            if (own_cmd == LIMP_NOP) begin
               if (cnt_q == CNT_W'(AMO_TIMEOUT - 1)) go_release = 1'b1;
               else                                  cnt_inc    = 1'b1;
            end else if (own_done) begin
               if (own_amo_ok) cnt_clr    = 1'b1;
               else            go_release = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         gnt_idx_q <= '0;
         grant_q   <= '0;
         locked_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sel_found) begin
                  if (sel_bad) begin
                     ptr_q <= inc_ptr(sel_idx);
                  end else begin
                     state_q   <= ST_BUSY;
                     gnt_idx_q <= sel_idx;
                     grant_q   <= sel_onehot;
                  end
               end
            end
            ST_BUSY, ST_AMO_LOCK: begin
               if (go_release) begin
                  state_q  <= ST_IDLE;
                  ptr_q    <= inc_ptr(gnt_idx_q);
                  grant_q  <= '0;
                  locked_q <= 1'b0;
                  cnt_q    <= '0;
               end else if (go_lock) begin
                  state_q  <= ST_AMO_LOCK;
                  locked_q <= 1'b1;
                  cnt_q    <= '0;
               end else if (cnt_clr) begin
                  cnt_q <= '0;
               end else if (cnt_inc) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               grant_q  <= '0;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   // Downstream forwarding and response routing to the owner only
   always_comb begin
      o_up_status = '0;
      o_up_rdata  = '0;
      o_dn_cmd    = LIMP_NOP;
      o_dn_addr   = '0;
      o_dn_wdata  = '0;
      o_dn_size   = LIMP_BYTE;
      if (state_q != ST_IDLE) begin
         o_dn_cmd   = up_cmd[gnt_idx_q];
         o_dn_addr  = up_addr[gnt_idx_q];
         o_dn_wdata = up_wdata[gnt_idx_q];
         o_dn_size  = up_size[gnt_idx_q];
         o_up_status[32'(gnt_idx_q)*2 +: 2]          = i_dn_status;
         o_up_rdata[DATA_W*32'(gnt_idx_q) +: DATA_W] = i_dn_rdata;
      end else if (sel_found && sel_bad) begin
         o_up_status[32'(sel_idx)*2 +: 2] = LIMP_READY_ILLEGAL;
      end
   end

   assign o_grant  = grant_q;
   assign o_locked = locked_q;

endmodule

// File: tb/tb_limp_rr_arbiter.sv
// Scoreboard bench for limp_rr_arbiter: per-port requester models, a simple target, and a
// monitor that pops expected responses whenever any port sees a ready status.
module tb_limp_rr_arbiter;

   localparam int unsigned NP = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;

   localparam logic [1:0] C_NOP = 2'd0, C_RD = 2'd1, C_WR = 2'd2, C_AMO = 2'd3;
   localparam logic [1:0] S_NR = 2'd0, S_RR = 2'd1, S_RW = 2'd2, S_IL = 2'd3;
   localparam logic [1:0] Z_BYTE = 2'd0, Z_WORD = 2'd2, Z_BAD = 2'd3;

   typedef struct packed {
      logic [1:0]  cmd;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic [1:0]  port;
      logic [1:0]  status;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tgt_ready = 1'b1;

   logic [2*NP-1:0]  up_cmd, up_size, up_status;
   logic [AW*NP-1:0] up_addr;
   logic [DW*NP-1:0] up_wdata, up_rdata;
   logic [1:0]       dn_cmd, dn_size, dn_status;
   logic [AW-1:0]    dn_addr;
   logic [DW-1:0]    dn_wdata, dn_rdata;
   logic [NP-1:0]    grant;
   logic             locked;

   logic [1:0]  cur_cmd   [NP];
   logic [31:0] cur_addr  [NP];
   logic [31:0] cur_wdata [NP];
   logic [1:0]  cur_size  [NP];
   logic        req_done  [NP];
   logic        abort_req [NP];

   req_t pq [NP][$];
   exp_t sb [$];
   exp_t mon_e;
   req_t rq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   limp_rr_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .AMO_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_up_cmd(up_cmd), .i_up_addr(up_addr), .i_up_wdata(up_wdata), .i_up_size(up_size),
      .o_up_status(up_status), .o_up_rdata(up_rdata),
      .o_dn_cmd(dn_cmd), .o_dn_addr(dn_addr), .o_dn_wdata(dn_wdata), .o_dn_size(dn_size),
      .i_dn_status(dn_status), .i_dn_rdata(dn_rdata),
      .o_grant(grant), .o_locked(locked)
   );

   always_comb begin
      for (int p = 0; p < NP; p++) begin
         up_cmd[2*p +: 2]     = cur_cmd[p];
         up_size[2*p +: 2]    = cur_size[p];
         up_addr[AW*p +: AW]  = cur_addr[p];
         up_wdata[DW*p +: DW] = cur_wdata[p];
      end
   end

   // Target: always ready when enabled, rejects bad size/cmd, read data tagged by address
   always_comb begin
      dn_status = S_NR;
      dn_rdata  = '0;
      if (tgt_ready && dn_cmd != C_NOP) begin
         if (dn_size == Z_BAD || (dn_cmd == C_AMO && dn_size != Z_WORD)) begin
            dn_status = S_IL;
         end else if (dn_cmd == C_WR) begin
            dn_status = S_RW;
         end else begin
            dn_status = S_RR;
            dn_rdata  = {16'hA5A5, dn_addr[15:0]};
         end
      end
   end

   // Requesters: hold a command until a ready status, then load the next queued one
   initial begin
      for (int p = 0; p < NP; p++) begin
         cur_cmd[p] = C_NOP; cur_addr[p] = '0; cur_wdata[p] = '0; cur_size[p] = Z_WORD;
         req_done[p] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int p = 0; p < NP; p++) req_done[p] = !rst && (up_status[2*p +: 2] != S_NR);
         @(posedge clk);
         #1;
         for (int p = 0; p < NP; p++) begin
            if (abort_req[p]) begin
               cur_cmd[p] = C_NOP;
            end else if (req_done[p] || cur_cmd[p] == C_NOP) begin
               if (pq[p].size() != 0) begin
                  rq = pq[p].pop_front();
                  cur_cmd[p] = rq.cmd; cur_addr[p] = rq.addr;
                  cur_size[p] = rq.size; cur_wdata[p] = rq.wdata;
               end else begin
                  cur_cmd[p] = C_NOP;
               end
            end
         end
      end
   end

   // Monitor: every ready status seen by a port must match the next expected response
   always @(negedge clk) begin
      if (!rst) begin
         for (int p = 0; p < NP; p++) begin
            if (up_status[2*p +: 2] != S_NR) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected: port %0d status %0d rdata %h, expected no response",
                           p, up_status[2*p +: 2], up_rdata[DW*p +: DW]);
               end else begin
                  mon_e = sb.pop_front();
                  if (mon_e.port != 2'(p) || mon_e.status != up_status[2*p +: 2] ||
                      mon_e.rdata != up_rdata[DW*p +: DW]) begin
                     errors++;
                     $display("FAIL sb_resp: got port %0d status %0d rdata %h, expected port %0d status %0d rdata %h",
                              p, up_status[2*p +: 2], up_rdata[DW*p +: DW],
                              mon_e.port, mon_e.status, mon_e.rdata);
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_req(input int p, input logic [1:0] cmd, input logic [31:0] addr,
                           input logic [1:0] size);
      req_t r;
      r.cmd = cmd; r.addr = addr; r.size = size; r.wdata = addr ^ 32'h1111_0000;
      pq[p].push_back(r);
   endtask

   task automatic push_exp(input int p, input logic [1:0] st, input logic [31:0] rd);
      exp_t e;
      e.port = 2'(p); e.status = st; e.rdata = rd;
      sb.push_back(e);
   endtask

   task automatic wait_grant(input string name, input logic [NP-1:0] g);
      int n = 0;
      while (grant != g && n < 50) begin tick(); n++; end
      check(name, 32'(grant), 32'(g));
   endtask

   task automatic wait_locked(input string name);
      int n = 0;
      while (!locked && n < 50) begin tick(); n++; end
      check(name, 32'(locked), 32'd1);
   endtask

   task automatic wait_ready(input string name, input int p);
      int n = 0;
      while (up_status[2*p +: 2] == S_NR && n < 50) begin tick(); n++; end
      check(name, 32'(up_status[2*p +: 2]), 32'(S_IL));
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin tick(); n++; end
      check(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int n;
      for (int p = 0; p < NP; p++) abort_req[p] = 1'b0;

      // Reset with every port requesting, then round-robin 0,1,2,3,0
      push_req(0, C_RD, 32'h0, Z_WORD);
      push_req(0, C_RD, 32'h0, Z_WORD);
      push_req(1, C_RD, 32'h1, Z_WORD);
      push_req(2, C_RD, 32'h2, Z_WORD);
      push_req(3, C_RD, 32'h3, Z_WORD);
      push_exp(0, S_RR, 32'hA5A5_0000);
      push_exp(1, S_RR, 32'hA5A5_0001);
      push_exp(2, S_RR, 32'hA5A5_0002);
      push_exp(3, S_RR, 32'hA5A5_0003);
      push_exp(0, S_RR, 32'hA5A5_0000);
      tick(); tick();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_dn_cmd", 32'(dn_cmd), 32'(C_NOP));
      check("rst_status", 32'(up_status), 32'd0);
      check("rst_rdata", up_rdata[31:0], 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      rst = 1'b0;
      tick();
      check("first_grant", 32'(grant), 32'b0001);
      check("first_dn_cmd", 32'(dn_cmd), 32'(C_RD));
      drain("rr_drain");

      // AMO lock holds port1 across its read/write pair while port2 waits
      push_req(1, C_AMO, 32'h8000_0010, Z_WORD);
      push_req(1, C_WR, 32'h8000_0010, Z_WORD);
      push_req(2, C_WR, 32'h20, Z_WORD);
      push_exp(1, S_RR, 32'hA5A5_0010);
      push_exp(1, S_RW, 32'h0);
      push_exp(2, S_RW, 32'h0);
      wait_locked("lock_set");
      check("lock_owner", 32'(grant), 32'b0010);
      drain("lock_drain");
      check("lock_clear", 32'(locked), 32'd0);

      // Lock timeout: owner idles, lock lasts exactly TO cycles, then pending port3 wins
      push_req(1, C_AMO, 32'h8000_0010, Z_WORD);
      push_exp(1, S_RR, 32'hA5A5_0010);
      wait_locked("to_lock_set");
      push_req(3, C_RD, 32'h3, Z_WORD);
      push_exp(3, S_RR, 32'hA5A5_0003);
      n = 0;
      while (locked && n < 40) begin n++; tick(); end
      check("to_len", 32'(n), 32'(TO));
      check("to_idle_grant", 32'(grant), 32'd0);
      tick();
      check("to_next_grant", 32'(grant), 32'b1000);
      drain("to_drain");

      // Illegal AMO size and reserved size
      push_req(2, C_AMO, 32'h40, Z_BYTE);
      push_exp(2, S_IL, 32'h0);
      wait_ready("ill_amo_status", 2);
`ifdef LIMP_ARB_ILLEGAL_CHECK_EN
      check("ill_amo_dn_cmd", 32'(dn_cmd), 32'(C_NOP));
      check("ill_amo_grant", 32'(grant), 32'd0);
`else
      check("ill_amo_dn_cmd", 32'(dn_cmd), 32'(C_AMO));
      check("ill_amo_grant", 32'(grant), 32'b0100);
`endif
      tick();
      check("ill_amo_one_cycle", 32'(up_status[5:4]), 32'(S_NR));
      check("ill_amo_no_lock", 32'(locked), 32'd0);
      push_req(0, C_RD, 32'h60, Z_BAD);
      push_exp(0, S_IL, 32'h0);
      wait_ready("ill_size_status", 0);
`ifdef LIMP_ARB_ILLEGAL_CHECK_EN
      check("ill_size_dn_cmd", 32'(dn_cmd), 32'(C_NOP));
`else
      check("ill_size_dn_cmd", 32'(dn_cmd), 32'(C_RD));
`endif
      drain("ill_drain");

      // Mid-op reset drops port0's stalled write and resets the pointer to 0
      tgt_ready = 1'b0;
      push_req(0, C_WR, 32'h50, Z_WORD);
      wait_grant("mid_grant", 4'b0001);
      push_req(3, C_RD, 32'h3, Z_WORD);
      tick(); tick();
      check("mid_dn_cmd", 32'(dn_cmd), 32'(C_WR));
      check("mid_dn_wdata", dn_wdata, 32'h1111_0050);
      rst = 1'b1;
      tick();
      check("mid_rst_dn_cmd", 32'(dn_cmd), 32'(C_NOP));
      check("mid_rst_grant", 32'(grant), 32'd0);
      rst = 1'b0;
      tick();
      check("mid_ptr0_grant", 32'(grant), 32'b0001);
      push_exp(0, S_RW, 32'h0);
      push_exp(3, S_RR, 32'hA5A5_0003);
      tgt_ready = 1'b1;
      drain("mid_drain");

      // Owner abort in BUSY: downstream sees NOP, pointer moves past the owner
      tgt_ready = 1'b0;
      push_req(1, C_RD, 32'h1, Z_WORD);
      wait_grant("abort_grant", 4'b0010);
      abort_req[1] = 1'b1;
      tick();
      check("abort_dn_cmd", 32'(dn_cmd), 32'(C_NOP));
      abort_req[1] = 1'b0;
      tick();
      check("abort_idle", 32'(grant), 32'd0);
      push_req(1, C_RD, 32'h1, Z_WORD);
      push_req(2, C_RD, 32'h2, Z_WORD);
      push_exp(2, S_RR, 32'hA5A5_0002);
      push_exp(1, S_RR, 32'hA5A5_0001);
      tgt_ready = 1'b1;
      drain("abort_drain");

      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
